// File: rtl/ram_req_seq.sv
// DCJ11 RAM request sequencer: turns bus read/write request levels into single
// PSRAM controller commands, with read timeout and post-write idle gap.
module ram_req_seq #(
  parameter int RD_TIMEOUT = 48,
  parameter int WR_GAP     = 4
) (
  input  logic        clk_x3,
  input  logic        rstb,
  input  logic        calib,
  input  logic [21:0] ram_addr,
  input  logic        ram_read,
  input  logic        ram_write,
  input  logic        ram_byte,
  input  logic [15:0] ram_wdata,
  output logic [15:0] ram_rdata,
  output logic        rd_done,
  output logic        busy,
  output logic        err,
  output logic        cmd_en,
  output logic        cmd,
  output logic [20:0] cmd_addr,
  output logic [15:0] wr_data,
  output logic [1:0]  data_mask,
  input  logic        rd_valid,
  input  logic [15:0] rd_data
);

  // state   | meaning
  // INIT    | waiting for controller calibration; requests stay pending
  // IDLE    | dispatch pending read (priority) or pending write
  // RD_CMD  | one-cycle read command strobe
  // RD_WAIT | waiting for rd_valid or timeout
  // WR_CMD  | one-cycle write command strobe
  // WR_GAP  | mandatory idle cycles after a write
  typedef enum logic [2:0] {
    INIT, IDLE, RD_CMD, RD_WAIT, WR_CMD, WR_GAP_ST
  } state_t;

  localparam int TO_W  = $clog2(RD_TIMEOUT + 1);
  localparam int GAP_W = (WR_GAP > 1) ? $clog2(WR_GAP + 1) : 1;

  state_t state, state_nxt;

  logic             wr_s1, wr_s2, wr_s3;
  logic             rd_q;
  logic             wr_edge, rd_edge;
  logic             pend_rd, pend_wr;
  logic [21:0]      pend_rd_addr, pend_wr_addr;
  logic [15:0]      pend_wdata;
  logic             pend_byte;
  logic [TO_W-1:0]  to_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             to_hit;
  logic             go_rd, go_wr;

  assign wr_edge = wr_s2 & ~wr_s3;
  assign rd_edge = ram_read & ~rd_q;
  assign to_hit  = (to_cnt == TO_W'(RD_TIMEOUT - 1));
  assign go_rd   = (state == IDLE) && (state_nxt == RD_CMD);
  assign go_wr   = (state == IDLE) && (state_nxt == WR_CMD);
  assign busy    = ((state != IDLE) && (state != INIT)) || pend_rd || pend_wr;

  always_ff @(posedge clk_x3) begin
    if (rstb) state <= INIT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_en    = 1'b0;
    case (state)
      INIT:    if (calib) state_nxt = IDLE;
      IDLE: begin
        // calib loss is only acted on between commands
        if (!calib)       state_nxt = INIT;
        else if (pend_rd) state_nxt = RD_CMD;
        else if (pend_wr) state_nxt = WR_CMD;
      end
      RD_CMD: begin
        cmd_en    = 1'b1;
        state_nxt = RD_WAIT;
      end
      RD_WAIT:   if (rd_valid || to_hit) state_nxt = IDLE;
      WR_CMD: begin
        cmd_en    = 1'b1;
        state_nxt = WR_GAP_ST;
      end
      WR_GAP_ST: if (gap_cnt == '0) state_nxt = IDLE;
      default:   state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk_x3) begin
    if (rstb) begin
      wr_s1        <= 1'b0;
      wr_s2        <= 1'b0;
      wr_s3        <= 1'b0;
      rd_q         <= 1'b0;
      pend_rd      <= 1'b0;
      pend_wr      <= 1'b0;
      pend_rd_addr <= '0;
      pend_wr_addr <= '0;
      pend_wdata   <= '0;
      pend_byte    <= 1'b0;
      to_cnt       <= '0;
      gap_cnt      <= '0;
      ram_rdata    <= '0;
      rd_done      <= 1'b0;
      err          <= 1'b0;
      cmd          <= 1'b0;
      cmd_addr     <= '0;
      wr_data      <= '0;
      data_mask    <= '0;
    end else begin
      wr_s1   <= ram_write;
      wr_s2   <= wr_s1;
      wr_s3   <= wr_s2;
      rd_q    <= ram_read;
      rd_done <= 1'b0;

      // pending flags clear as the command registers load; a same-cycle
      // new edge wins so it is never lost
      if (go_rd) pend_rd <= 1'b0;
      if (go_wr) pend_wr <= 1'b0;
      if (rd_edge) begin
        pend_rd      <= 1'b1;
        pend_rd_addr <= ram_addr;
      end
      if (wr_edge) begin
        pend_wr      <= 1'b1;
        pend_wr_addr <= ram_addr;
        pend_wdata   <= ram_wdata;
        pend_byte    <= ram_byte;
      end

      if (go_rd) begin
        cmd      <= 1'b0;
        cmd_addr <= pend_rd_addr[21:1];
      end
      if (go_wr) begin
        cmd      <= 1'b1;
        cmd_addr <= pend_wr_addr[21:1];
        if (pend_byte) begin
          wr_data   <= {pend_wdata[7:0], pend_wdata[7:0]};
          data_mask <= pend_wr_addr[0] ? 2'b01 : 2'b10;
        end else begin
          wr_data   <= pend_wdata;
          data_mask <= 2'b00;
        end
      end

      if (state == RD_CMD)
        to_cnt <= '0;
      else if ((state == RD_WAIT) && (to_cnt != '1))
        to_cnt <= to_cnt + 1'b1;

      if (state == RD_WAIT) begin
        if (rd_valid) begin
          ram_rdata <= rd_data;
          rd_done   <= 1'b1;
        end else if (to_hit) begin
          ram_rdata <= 16'hFFFF;
          err       <= 1'b1;
          rd_done   <= 1'b1;
        end
      end

      if (state == WR_CMD)
        gap_cnt <= GAP_W'(WR_GAP - 1);
      else if ((state == WR_GAP_ST) && (gap_cnt != '0))
        gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_req_seq.sv
// Directed bench for ram_req_seq: read, byte/word write, read/write collision,
// read timeout, calibration hold-off and reset during a read.
module tb_ram_req_seq;

  logic        clk_x3 = 1'b0;
  logic        rstb;
  logic        calib;
  logic [21:0] ram_addr;
  logic        ram_read;
  logic        ram_write;
  logic        ram_byte;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic        rd_done;
  logic        busy;
  logic        err;
  logic        cmd_en;
  logic        cmd;
  logic [20:0] cmd_addr;
  logic [15:0] wr_data;
  logic [1:0]  data_mask;
  logic        rd_valid;
  logic [15:0] rd_data;

  int n_checks = 0;
  int n_errors = 0;
  int n_cmd    = 0;
  int n_done   = 0;

  ram_req_seq #(.RD_TIMEOUT(48), .WR_GAP(4)) dut (
    .clk_x3    (clk_x3),
    .rstb      (rstb),
    .calib     (calib),
    .ram_addr  (ram_addr),
    .ram_read  (ram_read),
    .ram_write (ram_write),
    .ram_byte  (ram_byte),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .rd_done   (rd_done),
    .busy      (busy),
    .err       (err),
    .cmd_en    (cmd_en),
    .cmd       (cmd),
    .cmd_addr  (cmd_addr),
    .wr_data   (wr_data),
    .data_mask (data_mask),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
  );

  always #5 clk_x3 = ~clk_x3;

  always @(posedge clk_x3) begin
    if (cmd_en)  n_cmd  <= n_cmd + 1;
    if (rd_done) n_done <= n_done + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_x3);
  endtask

  // leaves the bench at the negedge where cmd_en is high
  task automatic wait_cmd(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk_x3);
      if (cmd_en) got = 1'b1;
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  task automatic wait_done(input string tag, output int lat);
    bit got = 1'b0;
    lat = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk_x3);
      lat++;
      if (rd_done) got = 1'b1;
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  int base_cmd, base_done, lat, k;

  initial begin
    rstb = 1'b1; calib = 1'b0; ram_addr = '0; ram_read = 1'b0; ram_write = 1'b0;
    ram_byte = 1'b0; ram_wdata = '0; rd_valid = 1'b0; rd_data = '0;
    cycles(3);
    chk("rst_rdata", 32'(ram_rdata), 32'h0);
    chk("rst_cmd_en", 32'(cmd_en), 32'h0);
    chk("rst_cmd", 32'(cmd), 32'h0);
    chk("rst_rd_done", 32'(rd_done), 32'h0);
    chk("rst_mask", 32'(data_mask), 32'h0);
    chk("rst_cmd_addr", 32'(cmd_addr), 32'h0);
    chk("rst_wr_data", 32'(wr_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rstb = 1'b0; calib = 1'b1;
    cycles(3);

    // simple read
    base_cmd = n_cmd; base_done = n_done;
    ram_addr = 22'o1000; ram_read = 1'b1;
    wait_cmd("rd1_seen");
    chk("rd1_cmd", 32'(cmd), 32'h0);
    chk("rd1_addr", 32'(cmd_addr), 32'(21'o400));
    ram_read = 1'b0;
    cycles(3);
    rd_valid = 1'b1; rd_data = 16'h1234;
    @(negedge clk_x3);
    rd_valid = 1'b0; rd_data = '0;
    chk("rd1_done_pulse", 32'(rd_done), 32'h1);
    chk("rd1_rdata", 32'(ram_rdata), 32'h1234);
    cycles(4);
    chk("rd1_ncmd", 32'(n_cmd - base_cmd), 32'd1);
    chk("rd1_ndone", 32'(n_done - base_done), 32'd1);
    chk("rd1_idle", 32'(busy), 32'h0);

    // stray rd_valid while idle must be ignored
    rd_valid = 1'b1; rd_data = 16'h7777;
    cycles(1);
    rd_valid = 1'b0;
    cycles(2);
    chk("stray_rdata", 32'(ram_rdata), 32'h1234);
    chk("stray_ndone", 32'(n_done - base_done), 32'd1);

    // byte write to odd address
    base_cmd = n_cmd;
    ram_addr = 22'o1001; ram_wdata = 16'h00AB; ram_byte = 1'b1; ram_write = 1'b1;
    wait_cmd("bw_seen");
    chk("bw_cmd", 32'(cmd), 32'h1);
    chk("bw_mask", 32'(data_mask), 32'h1);
    chk("bw_data", 32'(wr_data), 32'hABAB);
    chk("bw_addr", 32'(cmd_addr), 32'(21'o400));
    ram_write = 1'b0; ram_byte = 1'b0;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_x3);
      if (busy) k++;
      else break;
    end
    chk("bw_gap_cycles", 32'(k), 32'd4);
    chk("bw_ncmd", 32'(n_cmd - base_cmd), 32'd1);
    chk("bw_hold_data", 32'(wr_data), 32'hABAB);

    // read and write edges detected on the same clock: write leads by the
    // two synchroniser stages
    base_cmd = n_cmd; base_done = n_done;
    ram_addr = 22'o3000; ram_wdata = 16'hBEEF; ram_byte = 1'b0; ram_write = 1'b1;
    cycles(2);
    ram_read = 1'b1;
    wait_cmd("rw_rd_seen");
    chk("rw_first_cmd", 32'(cmd), 32'h0);
    chk("rw_rd_addr", 32'(cmd_addr), 32'(21'o1400));
    ram_read = 1'b0; ram_write = 1'b0;
    cycles(2);
    chk("rw_no_wr_yet", 32'(n_cmd - base_cmd), 32'd1);
    chk("rw_busy_wait", 32'(busy), 32'h1);
    rd_valid = 1'b1; rd_data = 16'h4321;
    @(negedge clk_x3);
    rd_valid = 1'b0;
    wait_cmd("rw_wr_seen");
    chk("rw_second_cmd", 32'(cmd), 32'h1);
    chk("rw_wr_data", 32'(wr_data), 32'hBEEF);
    chk("rw_wr_mask", 32'(data_mask), 32'h0);
    cycles(8);
    chk("rw_ncmd", 32'(n_cmd - base_cmd), 32'd2);
    chk("rw_ndone", 32'(n_done - base_done), 32'd1);
    chk("rw_rdata", 32'(ram_rdata), 32'h4321);
    chk("rw_idle", 32'(busy), 32'h0);

    // read timeout: 48 cycles in RD_WAIT, rd_done on the following cycle
    ram_addr = 22'o0; ram_read = 1'b1;
    wait_cmd("to_seen");
    ram_read = 1'b0;
    wait_done("to_done_seen", lat);
    chk("to_latency", 32'(lat), 32'd49);
    chk("to_rdata", 32'(ram_rdata), 32'hFFFF);
    chk("to_err", 32'(err), 32'h1);
    cycles(10);
    chk("to_err_sticky", 32'(err), 32'h1);

    // calibration low: write held pending until calib returns
    calib = 1'b0;
    cycles(2);
    base_cmd = n_cmd;
    ram_addr = 22'o2000; ram_wdata = 16'h12CD; ram_byte = 1'b1; ram_write = 1'b1;
    cycles(10);
    ram_write = 1'b0; ram_byte = 1'b0;
    chk("cal_no_cmd", 32'(n_cmd - base_cmd), 32'd0);
    chk("cal_busy", 32'(busy), 32'h1);
    calib = 1'b1;
    wait_cmd("cal_wr_seen");
    chk("cal_cmd", 32'(cmd), 32'h1);
    chk("cal_mask", 32'(data_mask), 32'h2);
    chk("cal_data", 32'(wr_data), 32'hCDCD);
    chk("cal_addr", 32'(cmd_addr), 32'(21'o1000));
    cycles(8);
    chk("cal_ncmd", 32'(n_cmd - base_cmd), 32'd1);

    // reset during RD_WAIT; calib held low so the FSM stays in INIT
    base_done = n_done;
    ram_addr = 22'o4000; ram_read = 1'b1;
    wait_cmd("rr_seen");
    ram_read = 1'b0;
    cycles(2);
    calib = 1'b0; rstb = 1'b1;
    cycles(2);
    rstb = 1'b0;
    base_cmd = n_cmd;
    rd_valid = 1'b1; rd_data = 16'h9999;
    cycles(2);
    rd_valid = 1'b0;
    cycles(3);
    chk("rr_rdata", 32'(ram_rdata), 32'h0);
    chk("rr_ndone", 32'(n_done - base_done), 32'd0);
    chk("rr_err_clr", 32'(err), 32'h0);
    chk("rr_busy", 32'(busy), 32'h0);
    chk("rr_ncmd", 32'(n_cmd - base_cmd), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
